// File: rtl/write_monitor_pkg.sv
// Shared definitions for the write_monitor test-completion monitor:
// FSM state encoding, pass_id codes, memwrite strobe codes and the
// store signatures that mark a passing test program.
package write_monitor_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

  // pass_id encodings
  localparam logic [1:0] PassNone      = 2'd0;
  localparam logic [1:0] PassStandard2 = 2'd1;
  localparam logic [1:0] PassPower2    = 2'd2;
  localparam logic [1:0] PassLoadStore = 2'd3;

  // memwrite strobe codes
  localparam logic [1:0] MwNone    = 2'b00;
  localparam logic [1:0] MwWord    = 2'b01;
  localparam logic [1:0] MwDouble  = 2'b10;
  localparam logic [1:0] MwIllegal = 2'b11;

  // Pass signatures: (store address, store data)
  localparam logic [63:0] SigStandard2Addr = 64'd100;
  localparam logic [63:0] SigStandard2Data = 64'd7;
  localparam logic [63:0] SigPower2Addr    = 64'd508;
  localparam logic [63:0] SigPower2Data    = 64'd7;
  localparam logic [63:0] SigLoadStoreAddr = 64'd80;
  localparam logic [63:0] SigLoadStoreData = 64'd1;

  localparam logic [9:0] WriteCountMax = 10'd1023;

endpackage

// File: rtl/sig_match.sv
// sig_match: combinational lookup of a store (address, data) pair against
// the pass-signature table.
//   dataadr, writedata : store being presented
//   hit                : pair equals one of the signatures (full 64-bit compare)
//   id                 : pass_id code of the matching signature, PassNone otherwise
module sig_match
  import write_monitor_pkg::*;
(
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  output logic        hit,
  output logic [1:0]  id
);

  always_comb begin
    hit = 1'b0;
    id  = PassNone;
    if (dataadr == SigStandard2Addr && writedata == SigStandard2Data) begin
      hit = 1'b1;
      id  = PassStandard2;
    end else if (dataadr == SigPower2Addr && writedata == SigPower2Data) begin
      hit = 1'b1;
      id  = PassPower2;
    end else if (dataadr == SigLoadStoreAddr && writedata == SigLoadStoreData) begin
      hit = 1'b1;
      id  = PassLoadStore;
    end
  end

endmodule

// File: rtl/write_monitor.sv
// write_monitor: watches CPU stores to decide whether a test program passed
// or failed, then drains for a fixed number of cycles before flagging done.
//   clk, reset           : clock, synchronous active-high reset
//   memwrite             : store strobe (00 none, 01 word, 10 dword, 11 illegal)
//   dataadr, writedata   : store address / data
//   pass, fail, done     : sticky result flags
//   pass_id              : which signature matched (0 when not passing)
//   illegal              : sticky, an illegal strobe was seen while running
//   write_count          : saturating count of accepted stores
//   last_addr, last_data : most recent accepted store
module write_monitor
  import write_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned DRAIN_CYCLES   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [63:0] dataadr,
  input  logic [63:0] writedata,
  output logic        pass,
  output logic        fail,
  output logic        done,
  output logic [1:0]  pass_id,
  output logic        illegal,
  output logic [9:0]  write_count,
  output logic [63:0] last_addr,
  output logic [63:0] last_data
);

  localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] DrainLoad   = 8'(DRAIN_CYCLES);

  state_e     state;
  logic [9:0] cyc_cnt;
  logic [7:0] drain_cnt;
  logic       hit;
  logic [1:0] hit_id;
  logic       accept;

  sig_match u_sig_match (
    .dataadr   (dataadr),
    .writedata (writedata),
    .hit       (hit),
    .id        (hit_id)
  );

  // Stores are recorded in RUN and DRAIN, including the illegal code.
  assign accept = (state != StDone) && (memwrite != MwNone);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StRun;
      cyc_cnt     <= '0;
      drain_cnt   <= '0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      done        <= 1'b0;
      pass_id     <= PassNone;
      illegal     <= 1'b0;
      write_count <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      if (accept) begin
        last_addr <= dataadr;
        last_data <= writedata;
        if (write_count != WriteCountMax) begin
          write_count <= write_count + 10'd1;
        end
      end

      case (state)
        StRun: begin
          cyc_cnt <= cyc_cnt + 10'd1;
          // Priority: illegal strobe, then signature match, then timeout.
          if (memwrite == MwIllegal) begin
            illegal   <= 1'b1;
            fail      <= 1'b1;
            drain_cnt <= DrainLoad;
            state     <= StDrain;
          end else if (memwrite != MwNone && hit) begin
            pass      <= 1'b1;
            pass_id   <= hit_id;
            drain_cnt <= DrainLoad;
            state     <= StDrain;
          end else if (cyc_cnt == TimeoutLast) begin
            fail      <= 1'b1;
            drain_cnt <= DrainLoad;
            state     <= StDrain;
          end
        end
        StDrain: begin
          if (drain_cnt == 8'd1) begin
            done  <= 1'b1;
            state <= StDone;
          end else begin
            drain_cnt <= drain_cnt - 8'd1;
          end
        end
        StDone: begin
          // Frozen until reset.
        end
        default: state <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_write_monitor.sv
// Bench for write_monitor: directed scenarios with literal expectations plus
// randomized episodes, all checked every cycle against an event-based model.
module tb_write_monitor;

  localparam int T = 48;
  localparam int D = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  memwrite = 2'b00;
  logic [63:0] dataadr = '0;
  logic [63:0] writedata = '0;
  logic        pass, fail, done, illegal;
  logic [1:0]  pass_id;
  logic [9:0]  write_count;
  logic [63:0] last_addr, last_data;

  write_monitor #(
    .TIMEOUT_CYCLES (T),
    .DRAIN_CYCLES   (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .pass        (pass),
    .fail        (fail),
    .done        (done),
    .pass_id     (pass_id),
    .illegal     (illegal),
    .write_count (write_count),
    .last_addr   (last_addr),
    .last_data   (last_data)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: the run is described by the edge index (n) at which the result was
  // decided (trig); drain and done windows follow from that index directly.
  bit          mvalid = 1'b0;
  int          n, trig;
  bit          m_pass, m_fail, m_done, m_illegal;
  int          m_id, m_cnt;
  logic [63:0] m_addr, m_data;

  function automatic int sig_id(input logic [63:0] a, input logic [63:0] d);
    if (a == 64'd100 && d == 64'd7) return 1;
    if (a == 64'd508 && d == 64'd7) return 2;
    if (a == 64'd80 && d == 64'd1) return 3;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mvalid = 1'b1;
      n = 0; trig = -1;
      m_pass = 0; m_fail = 0; m_done = 0; m_illegal = 0;
      m_id = 0; m_cnt = 0; m_addr = '0; m_data = '0;
    end else begin
      bit running;
      int sid;
      running = (trig < 0);
      if (memwrite != 2'b00 && (running || n <= trig + D)) begin
        if (m_cnt < 1023) m_cnt++;
        m_addr = dataadr;
        m_data = writedata;
      end
      if (running) begin
        sid = sig_id(dataadr, writedata);
        if (memwrite == 2'b11) begin
          m_illegal = 1; m_fail = 1; trig = n;
        end else if (memwrite != 2'b00 && sid != 0) begin
          m_pass = 1; m_id = sid; trig = n;
        end else if (n == T - 1) begin
          m_fail = 1; trig = n;
        end
      end
      if (trig >= 0 && n >= trig + D) m_done = 1;
      n++;
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("pass", 64'(pass), 64'(m_pass));
      chk("fail", 64'(fail), 64'(m_fail));
      chk("done", 64'(done), 64'(m_done));
      chk("illegal", 64'(illegal), 64'(m_illegal));
      chk("pass_id", 64'(pass_id), 64'(m_id));
      chk("write_count", 64'(write_count), 64'(m_cnt));
      chk("last_addr", last_addr, m_addr);
      chk("last_data", last_data, m_data);
    end
  end

  task automatic tick(input logic r, input logic [1:0] mw, input logic [63:0] a,
                      input logic [63:0] d);
    reset = r; memwrite = mw; dataadr = a; writedata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 2'b00, 64'd0, 64'd0);
  endtask

  initial begin
    // Standard2 signature in cycle 5
    tick(1'b1, 2'b00, 64'd0, 64'd0);
    chk("reset_pass", 64'(pass), 64'd0);
    chk("reset_count", 64'(write_count), 64'd0);
    idle(5);
    tick(1'b0, 2'b01, 64'd100, 64'd7);
    chk("std2_pass", 64'(pass), 64'd1);
    chk("std2_id", 64'(pass_id), 64'd1);
    chk("std2_count", 64'(write_count), 64'd1);
    idle(D - 1);
    chk("std2_done_early", 64'(done), 64'd0);
    idle(1);
    chk("std2_done", 64'(done), 64'd1);

    // Power2 after two plain stores
    tick(1'b1, 2'b00, 64'd0, 64'd0);
    tick(1'b0, 2'b10, 64'd0, 64'd3);
    tick(1'b0, 2'b10, 64'd8, 64'd4);
    tick(1'b0, 2'b10, 64'd508, 64'd7);
    chk("pow2_count", 64'(write_count), 64'd3);
    chk("pow2_id", 64'(pass_id), 64'd2);
    chk("pow2_addr", last_addr, 64'd508);
    chk("pow2_data", last_data, 64'd7);

    // Timeout
    tick(1'b1, 2'b00, 64'd0, 64'd0);
    idle(T - 1);
    chk("to_fail_early", 64'(fail), 64'd0);
    idle(1);
    chk("to_fail", 64'(fail), 64'd1);
    chk("to_pass", 64'(pass), 64'd0);
    idle(D - 1);
    chk("to_done_early", 64'(done), 64'd0);
    idle(1);
    chk("to_done", 64'(done), 64'd1);

    // Illegal strobe beats a signature
    tick(1'b1, 2'b00, 64'd0, 64'd0);
    tick(1'b0, 2'b11, 64'd80, 64'd1);
    chk("ill_illegal", 64'(illegal), 64'd1);
    chk("ill_fail", 64'(fail), 64'd1);
    chk("ill_pass", 64'(pass), 64'd0);

    // Match on the timeout cycle wins
    tick(1'b1, 2'b00, 64'd0, 64'd0);
    idle(T - 1);
    tick(1'b0, 2'b01, 64'd80, 64'd1);
    chk("tomatch_pass", 64'(pass), 64'd1);
    chk("tomatch_fail", 64'(fail), 64'd0);
    chk("tomatch_id", 64'(pass_id), 64'd3);

    // Stores in DRAIN counted, in DONE ignored
    tick(1'b1, 2'b00, 64'd0, 64'd0);
    tick(1'b0, 2'b01, 64'd100, 64'd7);
    for (int i = 0; i < 3; i++) tick(1'b0, 2'b10, 64'd508, 64'd7);
    idle(D - 3);
    chk("drain_done", 64'(done), 64'd1);
    for (int i = 0; i < 2; i++) tick(1'b0, 2'b01, 64'd100, 64'd7);
    chk("drain_count", 64'(write_count), 64'd4);
    chk("drain_id", 64'(pass_id), 64'd1);

    // Reset mid-DRAIN
    tick(1'b1, 2'b00, 64'd0, 64'd0);
    for (int i = 0; i < 4; i++) tick(1'b0, 2'b01, 64'(i * 8), 64'(i + 20));
    tick(1'b0, 2'b01, 64'd100, 64'd7);
    chk("rd_count5", 64'(write_count), 64'd5);
    idle(2);
    tick(1'b1, 2'b01, 64'd80, 64'd1);
    chk("rd_pass", 64'(pass), 64'd0);
    chk("rd_count", 64'(write_count), 64'd0);
    chk("rd_addr", last_addr, 64'd0);
    tick(1'b0, 2'b10, 64'd508, 64'd7);
    chk("rd_repass", 64'(pass), 64'd1);
    chk("rd_reid", 64'(pass_id), 64'd2);
    chk("rd_recount", 64'(write_count), 64'd1);

    // Random episodes
    for (int ep = 0; ep < 8; ep++) begin
      int rate;
      rate = (ep % 2 == 1) ? 45 : 6;
      tick(1'b1, 2'b00, 64'd0, 64'd0);
      for (int c = 0; c < 120; c++) begin
        logic [1:0]  mw;
        logic [63:0] a, d;
        int          r, s;
        r = $urandom_range(0, 99);
        if (r < 2) mw = 2'b11;
        else if (r < rate) mw = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        else mw = 2'b00;
        s = $urandom_range(0, 7);
        case (s)
          0: a = 64'd100;
          1: a = 64'd508;
          2: a = 64'd80;
          default: a = {$urandom, $urandom};
        endcase
        if ($urandom_range(0, 1) == 0) d = (s == 2) ? 64'd1 : 64'd7;
        else d = 64'($urandom_range(0, 9));
        tick(($urandom_range(0, 199) == 0), mw, a, d);
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/write_monitor.md
WRITE_MONITOR -- requirements
Module: write_monitor

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, RUN cycles allowed before a failure is declared (legal range 1..1023).
REQ-002 Parameter DRAIN_CYCLES, default 10, cycles held in DRAIN before done asserts (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 memwrite  input  2  store strobe from CPU top: 00 none, 01 word, 10 doubleword, 11 illegal.
REQ-006 dataadr  input  64  store byte address.
REQ-007 writedata  input  64  store data.
REQ-008 pass  output  1  sticky; a pass signature was matched.
REQ-009 fail  output  1  sticky; timeout or illegal strobe.
REQ-010 done  output  1  sticky; run finished and drain complete.
REQ-011 pass_id  output  2  matched signature: 0 none, 1 standard2, 2 power2, 3 loadstore.
REQ-012 illegal  output  1  sticky; memwrite==11 was seen in RUN.
REQ-013 write_count  output  10  number of stores accepted since reset, saturating.
REQ-014 last_addr / last_data  output  64 each  dataadr/writedata of most recent accepted store.

Function
REQ-015 States: RUN, DRAIN, DONE; reset enters RUN.
REQ-016 Store accepted in any cycle with memwrite!=00 while state is RUN or DRAIN; none accepted in DONE.
REQ-017 Each accepted store increments write_count by 1, saturating at 1023, and loads last_addr/last_data; visible the cycle after.
REQ-018 Signatures (dataadr, writedata): standard2=(100,7), power2=(508,7), loadstore=(80,1); full 64-bit equality; width code (01/10) ignored.
REQ-019 RUN: cycle counter increments each cycle; a signature-matching store with memwrite 01/10 sets pass, pass_id, loads drain counter with DRAIN_CYCLES, -> DRAIN.
REQ-020 RUN: memwrite==11 sets illegal and fail, -> DRAIN; illegal takes priority over a simultaneous signature match (pass stays 0).
REQ-021 RUN: when cycle counter reaches TIMEOUT_CYCLES-1 with no match/illegal that cycle, set fail, -> DRAIN; a match in that same cycle wins (pass, not fail).
REQ-022 DRAIN: drain counter decrements each cycle; stores still counted; further matches, illegal codes and timeouts ignored; at counter==1 -> DONE next edge.
REQ-023 DONE: done=1; all outputs frozen until reset.
REQ-024 pass and fail are never both 1; pass_id!=0 iff pass=1.
REQ-025 Latency: pass/fail/illegal visible 1 cycle after the triggering edge; done exactly DRAIN_CYCLES cycles after pass/fail.

Reset
REQ-026 While reset=1 at a rising edge: state RUN, both counters 0, pass/fail/done/illegal 0, pass_id 0, write_count 0, last_addr/last_data 0.
REQ-027 Reset asserted mid-RUN, mid-DRAIN or in DONE restarts fully; a store presented during the reset cycle is not counted.

Structure
REQ-028 Shared package holds state enum, pass_id encodings, memwrite codes, and the three signature address/data constants.
REQ-029 One sub-module, sig_match: combinational compare of dataadr/writedata against the signature table returning hit and id.

Verification
REQ-030 Reset, then store (100,7) code 01 in cycle 5 -> pass=1, pass_id=1, write_count=1, done=1 ten cycles later.
REQ-031 Stores (0,3),(8,4),(508,7) code 10 -> write_count=3, pass_id=2, last_addr=508, last_data=7.
REQ-032 TIMEOUT_CYCLES=48, no stores -> fail=1 after cycle 48, pass=0, done 10 cycles later.
REQ-033 Store (80,1) code 11 -> illegal=1, fail=1, pass=0; store (80,1) code 01 on timeout cycle -> pass=1, fail=0.
REQ-034 Match then stores (100,7) in DRAIN and DONE -> pass_id unchanged, write_count counts DRAIN stores only.
REQ-035 Assert reset during DRAIN after 5 stores -> all outputs 0 next cycle; new match passes normally.
